multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over a single shared memory port with a req/ready handshake. It issues the per-state enables for the PC, IR, ALUOut, MDR and register file, and counts retired instructions. It sits beside the combinational opcode decoder: the decoder drives ALU operand and operation selects, and this block decides when each datapath register captures.

## Interface
- OPWIDTH, 7, opcode field width (inst[6:0]).
- CNTWIDTH, 32, width of the retired-instruction counter.
- TIMEOUT, 255, maximum cycles to wait for mem_ready before faulting; legal range 1..255.

- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  start/continue enable, sampled in IDLE only.
- opcode  in  OPWIDTH  opcode of the instruction currently held in IR.
- br_taken  in  1  branch comparison result from the ALU, valid in EXEC.
- mem_ready  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  capture the memory read data into IR.
- mdr_write  out  1  capture the memory read data into MDR.
- aluout_write  out  1  capture the ALU result.
- pc_write  out  1  update PC.
- pc_src  out  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- halted  out  1  FSM is in HALT.
- err  out  2  fault code: 0 = none, 1 = illegal opcode, 2 = memory timeout.
- instret  out  CNTWIDTH  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. State is registered.
- Outputs are combinational from the state, plus mem_ready where noted. Every output not listed for a state is 0.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.

State behaviour:
- IDLE: all outputs 0. Moves to FETCH when run=1.
- FETCH: mem_req=1, iord=0, ir_write=mem_ready. Moves to DECODE on mem_ready.
- DECODE: no enables, one cycle.
  - Illegal opcode: go to HALT and set err=1.
  - Otherwise go to EXEC.
- EXEC: aluout_write=1 and pc_write=1, one cycle.
  - pc_src: 1 for JAL, or for BRANCH with br_taken=1. 2 for JALR. 0 otherwise.
  - Next state: load or store goes to MEM. BRANCH goes to FETCH. All other opcodes go to WB.
- MEM: mem_req=1, iord=1, mem_we=1 for store.
  - Load: mdr_write=mem_ready.
  - On mem_ready, a load goes to WB and a store goes to FETCH.
- WB: reg_write=1, mem_to_reg=1 for load. One cycle, then FETCH.
- HALT: halted=1 and err holds its value. Only reset leaves HALT.

Counters:
- Wait counter (8 bits) clears on every state change.
- It increments each FETCH/MEM cycle with mem_ready=0.
- When it equals TIMEOUT with mem_ready still 0: go to HALT and set err=2.
- mem_ready=1 in the same cycle the count is reached wins: the handshake completes and no fault is raised.
- instret increments by 1 on each retire:
  - leaving WB;
  - leaving MEM for a store;
  - leaving EXEC for a BRANCH.
- instret wraps modulo 2^CNTWIDTH.

## Timing
- Reset (rst_n=0 at a rising edge) forces state=IDLE, err=0, instret=0 and wait counter=0. This applies in every state, including mid-handshake.
- All outputs are 0 in the cycle after a reset edge.
- A memory request outstanding at reset is abandoned; mem_req deasserts after the reset edge.
- Handshake rules:
  - mem_req is held high from the first FETCH/MEM cycle until the cycle in which mem_ready=1, inclusive.
  - The transfer completes in the mem_ready cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the first request cycle):
  - R/I/LUI/AUIPC/JAL/JALR: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each memory wait cycle adds 1.
- run is ignored outside IDLE; the FSM never returns to IDLE except through reset.
- Illegal-opcode detection occurs in DECODE: halted rises one cycle after DECODE.

## Test plan
- Reset, run=1, zero-wait memory, opcode=0110011 -> state sequence FETCH, DECODE, EXEC, WB, FETCH; reg_write=1 for exactly one cycle; instret=1 after WB.
- Load (0000011) with mem_ready delayed 3 cycles in MEM -> mem_req=1 and iord=1 for 4 cycles; mdr_write pulses only in the 4th; then WB with mem_to_reg=1. Store (0100011) -> mem_we=1, no WB, instret increments on leaving MEM.
- Branch with br_taken=1 -> pc_src=1, pc_write=1 in EXEC, back to FETCH, instret+1. JALR -> pc_src=2, then WB.
- opcode=1111111 -> HALT one cycle after DECODE, halted=1, err=1; run and mem_ready toggling have no effect until rst_n=0.
- mem_ready held 0 in FETCH with TIMEOUT=4 -> HALT with err=2 after 5 FETCH cycles. Rerun with mem_ready=1 exactly on the 5th FETCH cycle -> DECODE, no fault.
- rst_n=0 asserted mid-MEM with mem_req high -> next cycle IDLE, mem_req=0, instret=0. Preload instret to 2^32-1 and retire one instruction -> instret=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Control FSM for a multi-cycle RV32I core. Walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB over one shared memory port (req/ready),
// raises the per-state datapath capture enables, flags illegal opcodes and
// memory timeouts, and counts retired instructions.
module multicycle_sequencer #(
  parameter int OPWIDTH  = 7,
  parameter int CNTWIDTH = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPWIDTH-1:0]  opcode,
  input  logic                br_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                aluout_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                halted,
  output logic [1:0]          err,
  output logic [CNTWIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  localparam logic [OPWIDTH-1:0] OP_R      = OPWIDTH'(7'b0110011);
  localparam logic [OPWIDTH-1:0] OP_I      = OPWIDTH'(7'b0010011);
  localparam logic [OPWIDTH-1:0] OP_LOAD   = OPWIDTH'(7'b0000011);
  localparam logic [OPWIDTH-1:0] OP_STORE  = OPWIDTH'(7'b0100011);
  localparam logic [OPWIDTH-1:0] OP_BRANCH = OPWIDTH'(7'b1100011);
  localparam logic [OPWIDTH-1:0] OP_JAL    = OPWIDTH'(7'b1101111);
  localparam logic [OPWIDTH-1:0] OP_JALR   = OPWIDTH'(7'b1100111);
  localparam logic [OPWIDTH-1:0] OP_LUI    = OPWIDTH'(7'b0110111);
  localparam logic [OPWIDTH-1:0] OP_AUIPC  = OPWIDTH'(7'b0010111);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_wait_cnt;
  logic [7:0]          w_wait_nxt;
  logic [1:0]          r_err;
  logic [1:0]          w_err_nxt;
  logic [CNTWIDTH-1:0] r_instret;
  logic                w_retire;

  logic w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_legal;
  logic w_mem_phase, w_timeout;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_jal    = (opcode == OP_JAL);
  assign w_is_jalr   = (opcode == OP_JALR);
  assign w_legal     = (opcode == OP_R) || (opcode == OP_I) || w_is_load ||
                       w_is_store || w_is_branch || w_is_jal || w_is_jalr ||
                       (opcode == OP_LUI) || (opcode == OP_AUIPC);

  // A completing handshake beats the timeout, so the fault needs ready low.
  assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timeout   = (r_wait_cnt == 8'(TIMEOUT)) && !mem_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, fault code and retire decision.
  always_comb begin
    // NOTE: defaults first so every path assigns; otherwise latches appear.
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          w_state_nxt = ST_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ST_HALT;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!w_legal) begin
          w_state_nxt = ST_HALT;
          w_err_nxt   = ERR_ILLEGAL;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_is_load || w_is_store) begin
          w_state_nxt = ST_MEM;
        end else if (w_is_branch) begin
          w_state_nxt = ST_FETCH;
          w_retire    = 1'b1;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (w_is_load) begin
            w_state_nxt = ST_WB;
          end else begin
            w_state_nxt = ST_FETCH;
            w_retire    = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_HALT;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        w_state_nxt = ST_FETCH;
        w_retire    = 1'b1;
      end
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: restarts on any state change, counts stalled request cycles.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (w_state_nxt != r_state)        w_wait_nxt = 8'd0;
    else if (w_mem_phase && !mem_ready) w_wait_nxt = r_wait_cnt + 8'd1;
  end

  // Wait counter, fault code and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
      r_err      <= ERR_NONE;
      r_instret  <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
      if (w_retire) r_instret <= r_instret + CNTWIDTH'(1);
    end
  end

  // Per-state datapath enables and memory handshake outputs.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    aluout_write = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      ST_EXEC: begin
        aluout_write = 1'b1;
        pc_write     = 1'b1;
        if (w_is_jal || (w_is_branch && br_taken)) pc_src = 2'd1;
        else if (w_is_jalr)                         pc_src = 2'd2;
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = w_is_store;
        mdr_write = w_is_load && mem_ready;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_load;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign err     = r_err;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer. A main instance (TIMEOUT=4)
// carries all checks; a second instance with a 2-bit counter shares the
// inputs so counter wrap-around is visible after four retirements.
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ILL  = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n, run, br_taken, mem_ready;
  logic [6:0]  opcode;

  logic        mem_req, mem_we, iord, ir_write, mdr_write, aluout_write;
  logic        pc_write, reg_write, mem_to_reg, halted;
  logic [1:0]  pc_src, err;
  logic [31:0] instret;

  logic        b_mem_req, b_mem_we, b_iord, b_ir_write, b_mdr_write;
  logic        b_aluout_write, b_pc_write, b_reg_write, b_mem_to_reg, b_halted;
  logic [1:0]  b_pc_src, b_err;
  logic [1:0]  b_instret;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_sequencer #(.OPWIDTH(7), .CNTWIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .mdr_write(mdr_write), .aluout_write(aluout_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .halted(halted), .err(err), .instret(instret)
  );

  multicycle_sequencer #(.OPWIDTH(7), .CNTWIDTH(2), .TIMEOUT(255)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord),
    .ir_write(b_ir_write), .mdr_write(b_mdr_write),
    .aluout_write(b_aluout_write), .pc_write(b_pc_write),
    .pc_src(b_pc_src), .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg),
    .halted(b_halted), .err(b_err), .instret(b_instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  // Expected output word: {req,we,iord,irw,mdrw,aluw,pcw,pc_src,rw,m2r,halt,err}
  function automatic logic [13:0] mk(input logic req, we, io, irw, mdrw, aluw,
                                     pcw, input logic [1:0] pcs,
                                     input logic rw, m2r, hlt,
                                     input logic [1:0] e);
    return {req, we, io, irw, mdrw, aluw, pcw, pcs, rw, m2r, hlt, e};
  endfunction

  function automatic logic [13:0] sig();
    return {mem_req, mem_we, iord, ir_write, mdr_write, aluout_write,
            pc_write, pc_src, reg_write, mem_to_reg, halted, err};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then apply this cycle's inputs and let them settle.
  task automatic nxt(input logic r, input logic [6:0] op, input logic b,
                     input logic rdy);
    @(posedge clk);
    #1;
    run = r; opcode = op; br_taken = b; mem_ready = rdy;
    #1;
  endtask

  logic [13:0] IDLE0, FETCH_W, FETCH_R, EXEC0, EXEC1, EXEC2, WB_ALU, WB_MDR;
  logic [13:0] MEM_LD_W, MEM_LD_R, MEM_ST_R;

  initial begin
    IDLE0    = '0;
    FETCH_W  = mk(1,0,0,0,0,0,0,2'd0,0,0,0,2'd0);
    FETCH_R  = mk(1,0,0,1,0,0,0,2'd0,0,0,0,2'd0);
    EXEC0    = mk(0,0,0,0,0,1,1,2'd0,0,0,0,2'd0);
    EXEC1    = mk(0,0,0,0,0,1,1,2'd1,0,0,0,2'd0);
    EXEC2    = mk(0,0,0,0,0,1,1,2'd2,0,0,0,2'd0);
    WB_ALU   = mk(0,0,0,0,0,0,0,2'd0,1,0,0,2'd0);
    WB_MDR   = mk(0,0,0,0,0,0,0,2'd0,1,1,0,2'd0);
    MEM_LD_W = mk(1,0,1,0,0,0,0,2'd0,0,0,0,2'd0);
    MEM_LD_R = mk(1,0,1,0,1,0,0,2'd0,0,0,0,2'd0);
    MEM_ST_R = mk(1,1,1,0,0,0,0,2'd0,0,0,0,2'd0);

    rst_n = 1'b0; run = 1'b0; opcode = OP_R; br_taken = 1'b0; mem_ready = 1'b0;
    repeat (2) nxt(0, OP_R, 0, 0);
    check("reset_outputs", 64'(sig()), 64'(IDLE0));
    check("reset_instret", 64'(instret), 64'd0);
    rst_n = 1'b1;

    // IDLE ignores mem_ready; run is sampled at the following edge.
    nxt(0, OP_R, 0, 1);  check("idle_ready_ignored", 64'(sig()), 64'(IDLE0));
    nxt(1, OP_R, 0, 1);  check("idle_before_run", 64'(sig()), 64'(IDLE0));

    // R-type, zero-wait: FETCH, DECODE, EXEC, WB, FETCH.
    nxt(0, OP_R, 0, 1);  check("r_fetch", 64'(sig()), 64'(FETCH_R));
    nxt(0, OP_R, 0, 1);  check("r_decode", 64'(sig()), 64'(IDLE0));
    nxt(0, OP_R, 0, 1);  check("r_exec", 64'(sig()), 64'(EXEC0));
    nxt(0, OP_R, 0, 1);  check("r_wb", 64'(sig()), 64'(WB_ALU));
    check("r_instret_in_wb", 64'(instret), 64'd0);

    // Load with three MEM wait cycles.
    nxt(0, OP_LD, 0, 1); check("ld_fetch", 64'(sig()), 64'(FETCH_R));
    check("r_instret_after_wb", 64'(instret), 64'd1);
    nxt(0, OP_LD, 0, 1); check("ld_decode", 64'(sig()), 64'(IDLE0));
    nxt(0, OP_LD, 0, 0); check("ld_exec", 64'(sig()), 64'(EXEC0));
    for (int i = 0; i < 3; i++) begin
      nxt(0, OP_LD, 0, 0); check("ld_mem_wait", 64'(sig()), 64'(MEM_LD_W));
    end
    nxt(0, OP_LD, 0, 1); check("ld_mem_done", 64'(sig()), 64'(MEM_LD_R));
    nxt(0, OP_LD, 0, 1); check("ld_wb", 64'(sig()), 64'(WB_MDR));
    check("ld_instret_in_wb", 64'(instret), 64'd1);

    // Store: MEM goes straight back to FETCH and retires there.
    nxt(0, OP_ST, 0, 1); check("st_fetch", 64'(sig()), 64'(FETCH_R));
    check("ld_instret_after_wb", 64'(instret), 64'd2);
    nxt(0, OP_ST, 0, 1); check("st_decode", 64'(sig()), 64'(IDLE0));
    nxt(0, OP_ST, 0, 1); check("st_exec", 64'(sig()), 64'(EXEC0));
    nxt(0, OP_ST, 0, 1); check("st_mem", 64'(sig()), 64'(MEM_ST_R));
    check("st_instret_in_mem", 64'(instret), 64'd2);

    // Taken branch: retires leaving EXEC.
    nxt(0, OP_BR, 1, 1); check("br_fetch", 64'(sig()), 64'(FETCH_R));
    check("st_instret_after_mem", 64'(instret), 64'd3);
    nxt(0, OP_BR, 1, 1); check("br_decode", 64'(sig()), 64'(IDLE0));
    nxt(0, OP_BR, 1, 1); check("br_exec_taken", 64'(sig()), 64'(EXEC1));

    // JALR: pc_src=2, then WB.
    nxt(0, OP_JALR, 0, 1); check("jalr_fetch", 64'(sig()), 64'(FETCH_R));
    check("br_instret", 64'(instret), 64'd4);
    check("wrap_instret_zero", 64'(b_instret), 64'd0);
    nxt(0, OP_JALR, 0, 1); check("jalr_decode", 64'(sig()), 64'(IDLE0));
    nxt(0, OP_JALR, 0, 1); check("jalr_exec", 64'(sig()), 64'(EXEC2));
    nxt(0, OP_JALR, 0, 1); check("jalr_wb", 64'(sig()), 64'(WB_ALU));

    // FETCH with ready arriving exactly on the count limit: no fault.
    for (int i = 0; i < 4; i++) begin
      nxt(0, OP_R, 0, 0); check("fetch_wait", 64'(sig()), 64'(FETCH_W));
    end
    check("jalr_instret", 64'(instret), 64'd5);
    check("wrap_instret_one", 64'(b_instret), 64'd1);
    nxt(0, OP_R, 0, 1);   check("fetch_ready_at_limit", 64'(sig()), 64'(FETCH_R));

    // Illegal opcode seen in DECODE, then HALT with err=1.
    nxt(0, OP_ILL, 0, 1); check("ill_decode", 64'(sig()), 64'(IDLE0));
    nxt(1, OP_ILL, 0, 0);
    check("ill_halt", 64'(sig()), 64'(mk(0,0,0,0,0,0,0,2'd0,0,0,1,2'd1)));
    nxt(0, OP_R, 0, 1);
    nxt(1, OP_R, 0, 1);
    check("ill_halt_sticky", 64'(sig()), 64'(mk(0,0,0,0,0,0,0,2'd0,0,0,1,2'd1)));
    check("ill_instret", 64'(instret), 64'd5);

    // Reset out of HALT.
    rst_n = 1'b0;
    nxt(0, OP_R, 0, 0);
    check("halt_reset_outputs", 64'(sig()), 64'(IDLE0));
    check("halt_reset_instret", 64'(instret), 64'd0);
    rst_n = 1'b1;

    // Memory timeout in FETCH: five stalled cycles, then HALT with err=2.
    nxt(1, OP_R, 0, 0);  check("to_idle", 64'(sig()), 64'(IDLE0));
    for (int i = 0; i < 5; i++) begin
      nxt(0, OP_R, 0, 0); check("to_fetch_wait", 64'(sig()), 64'(FETCH_W));
    end
    nxt(0, OP_R, 0, 0);
    check("to_halt", 64'(sig()), 64'(mk(0,0,0,0,0,0,0,2'd0,0,0,1,2'd2)));

    // Reset abandons a pending MEM request and clears instret.
    rst_n = 1'b0;
    nxt(1, OP_R, 0, 1);
    rst_n = 1'b1;
    nxt(1, OP_R, 0, 1);  check("mr_fetch", 64'(sig()), 64'(FETCH_R));
    nxt(0, OP_R, 0, 1);
    nxt(0, OP_R, 0, 1);
    nxt(0, OP_R, 0, 1);  check("mr_wb", 64'(sig()), 64'(WB_ALU));
    nxt(0, OP_LD, 0, 1);
    nxt(0, OP_LD, 0, 1);
    nxt(0, OP_LD, 0, 0);
    nxt(0, OP_LD, 0, 0); check("mr_mem_pending", 64'(sig()), 64'(MEM_LD_W));
    check("mr_instret_before", 64'(instret), 64'd1);
    rst_n = 1'b0;
    nxt(0, OP_LD, 0, 0);
    check("mr_reset_outputs", 64'(sig()), 64'(IDLE0));
    check("mr_reset_instret", 64'(instret), 64'd0);
    rst_n = 1'b1;
    nxt(0, OP_LD, 0, 1); check("mr_stays_idle", 64'(sig()), 64'(IDLE0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
